serial_shift_ctrl: RTL and testbench

- Controller that sequences a parallel-load right/left shift register, a bit counter and a bit-period tick counter.
- Serializes one WIDTH-bit word per transaction onto a single line.
- Accepts words over a valid/ready handshake and signals completion with a pulse.
- Sits between a parallel producer (register/FIFO stage) and a serial consumer in the sequential-logic subsystem.

---
 rtl/serial_shift_ctrl.sv | 99 +++++++++
 tb/tb_serial_shift_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/serial_shift_ctrl.sv
// Serializes one parallel word per handshake onto serial_out, holding each bit
// for div+1 clocks, in LSB-first or MSB-first order, with a done pulse at the end.
module serial_shift_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [DIV_W-1:0]         div,
  input  logic                     lsb_first,
  output logic                     serial_out,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   shift_reg;
  logic [IDX_W-1:0]   bit_cnt_reg;
  logic [DIV_W-1:0]   tick_cnt_reg;
  logic [DIV_W-1:0]   div_reg;
  logic               dir_reg;

  logic [WIDTH-1:0]   shift_next;
  logic               bit_next;

  // The bit adjacent to the output end becomes the next bit on the line.
  always_comb begin
    shift_next = dir_reg ? (shift_reg >> 1) : (shift_reg << 1);
    bit_next   = dir_reg ? shift_reg[1] : shift_reg[WIDTH-2];
  end

  assign in_ready = (state_reg == IDLE);
  assign bit_idx  = bit_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      tick_cnt_reg <= '0;
      div_reg      <= '0;
      dir_reg      <= 1'b0;
      serial_out   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          serial_out <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          if (in_valid) begin
            shift_reg    <= in_data;
            div_reg      <= div;
            dir_reg      <= lsb_first;
            bit_cnt_reg  <= '0;
            tick_cnt_reg <= '0;
            busy         <= 1'b1;
            serial_out   <= lsb_first ? in_data[0] : in_data[WIDTH-1];
            state_reg    <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick_cnt_reg == div_reg) begin
            tick_cnt_reg <= '0;
            if (bit_cnt_reg == LAST_BIT) begin
              serial_out <= 1'b0;
              done       <= 1'b1;
              state_reg  <= DONE;
            end else begin
              shift_reg   <= shift_next;
              serial_out  <= bit_next;
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
          end
        end
        DONE: begin
          done        <= 1'b0;
          busy        <= 1'b0;
          bit_cnt_reg <= '0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shift_ctrl.sv
// Randomized and directed bench for serial_shift_ctrl; a per-cycle expected
// trace is generated from the word, divider and bit order at each accept.
module tb_serial_shift_ctrl;

  localparam int WIDTH = 8;
  localparam int DIV_W = 8;
  localparam int IDX_W = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [DIV_W-1:0] div = '0;
  logic             lsb_first = 1'b0;
  logic             serial_out;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] bit_idx;

  serial_shift_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .div(div), .lsb_first(lsb_first),
    .serial_out(serial_out), .busy(busy), .done(done), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic so;
    logic bsy;
    logic dn;
    logic rdy;
    int   idx;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  int   errors = 0;
  int   checks = 0;
  int   words  = 0;

  function automatic rec_t idle_rec();
    rec_t r;
    r.so = 1'b0; r.bsy = 1'b0; r.dn = 1'b0; r.rdy = 1'b1; r.idx = 0;
    return r;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected trace of a word: WIDTH bits each lasting d+1 cycles, then one done cycle.
  task automatic model_accept(input logic [WIDTH-1:0] data, input int d, input logic lsb);
    rec_t r;
    for (int b = 0; b < WIDTH; b++) begin
      for (int t = 0; t <= d; t++) begin
        r.so  = lsb ? data[b] : data[WIDTH-1-b];
        r.bsy = 1'b1; r.dn = 1'b0; r.rdy = 1'b0; r.idx = b;
        q.push_back(r);
      end
    end
    r.so = 1'b0; r.bsy = 1'b1; r.dn = 1'b1; r.rdy = 1'b0; r.idx = WIDTH - 1;
    q.push_back(r);
    words++;
    $display("word %0d accepted data=%h div=%0d lsb_first=%0b", words, data, d, lsb);
  endtask

  // One clock: check this cycle's outputs, drive inputs for the coming edge, advance model.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] data,
                       input logic [DIV_W-1:0] d, input logic lsb);
    @(negedge clk);
    check("serial_out", int'(serial_out), int'(cur.so));
    check("busy", int'(busy), int'(cur.bsy));
    check("done", int'(done), int'(cur.dn));
    check("in_ready", int'(in_ready), int'(cur.rdy));
    if (cur.bsy && !cur.dn) check("bit_idx", int'(bit_idx), cur.idx);
    in_valid = v; in_data = data; div = d; lsb_first = lsb;
    if (v && cur.rdy) model_accept(data, int'(d), lsb);
    cur = (q.size() > 0) ? q.pop_front() : idle_rec();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_serial_out", int'(serial_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_bit_idx", int'(bit_idx), 0);
    q.delete();
    cur = idle_rec();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offer one word, then scramble the idle-side inputs until the word completes.
  task automatic send(input logic [WIDTH-1:0] data, input logic [DIV_W-1:0] d, input logic lsb);
    cycle(1'b1, data, d, lsb);
    while (!cur.rdy)
      cycle(1'b0, WIDTH'($urandom), DIV_W'($urandom), 1'($urandom));
  endtask

  initial begin
    cur = idle_rec();
    do_reset();
    repeat (20) cycle(1'b0, '0, '0, 1'b0);

    send(8'hA5, 8'd0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0);
    send(8'hC3, 8'd2, 1'b0);

    // Held-valid back-to-back: 01 then FF, garbage div/data while busy.
    cycle(1'b1, 8'h01, 8'd0, 1'b1);
    while (!cur.rdy) cycle(1'b1, WIDTH'($urandom), DIV_W'($urandom), 1'($urandom));
    send(8'hFF, 8'd0, 1'b1);

    // Abort mid-word during bit 4 of 5A.
    cycle(1'b1, 8'h5A, 8'd1, 1'b1);
    repeat (9) cycle(1'b0, '0, '0, 1'b0);
    do_reset();
    repeat (5) cycle(1'b0, '0, '0, 1'b0);
    send(8'h5A, 8'd1, 1'b1);

    send(8'h80, 8'hFF, 1'b1);
    repeat (2) cycle(1'b0, '0, '0, 1'b0);

    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 3) == 0), WIDTH'($urandom),
            DIV_W'($urandom_range(0, 3)), 1'($urandom));
    while (!cur.rdy) cycle(1'b0, '0, '0, 1'b0);
    repeat (3) cycle(1'b0, '0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
